// File: rtl/epitaxc_pkg.sv
// +--------------------------------------------------------------+
// | epitaxc_pkg : shared SAR ADC controller types and defaults    |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

package epitaxc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      SETTLE = 2'd2,
      DECIDE = 2'd3
   } state_t;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_SAMPLE_CYCLES = 4;
   localparam int DEF_SETTLE_CYCLES = 2;

   // Width of a cycle counter able to hold the largest of the three limits.
   function automatic int cnt_width(input int s, input int t, input int w);
      int m;
      m = s;
      if (t > m) m = t;
      if (w > m) m = w;
      return $clog2(m) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sar_adc_ctrl_sync2.sv
// +--------------------------------------------------------------+
// | sync2 : two-flop synchronizer for asynchronous inputs         |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
// +--------------------------------------------------------------+
// | sar_adc_ctrl : successive-approximation ADC controller        |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module sar_adc_ctrl
   import epitaxc_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             comp_i,
   output logic             sample_o,
   output logic [WIDTH-1:0] dac_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] result_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES, WIDTH);
   localparam int IDX_W = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic               comp_sync;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [WIDTH-1:0]   sar;
   logic [WIDTH-1:0]   decided;
   logic [WIDTH-1:0]   next_trial;
   logic [WIDTH-1:0]   result;
   logic               valid;
   logic               cnt_done;

   sync2 u_comp_sync (
      .clk (clk),
      .rst (rst),
      .d   (comp_i),
      .q   (comp_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cnt_done   = 1'b0;
      decided    = sar;
      decided[idx] = comp_sync;
      // Next-lower trial bit; evaluates to zero at the LSB.
      next_trial = decided | ((WIDTH'(1) << idx) >> 1);
      case (state)
         IDLE: begin
            if (start_i && (!valid || ready_i)) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
               cnt_done  = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               cnt_done  = 1'b1;
               state_nxt = DECIDE;
            end
         end
         DECIDE: begin
            state_nxt = (idx == '0) ? IDLE : SETTLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= '0;
         sar    <= '0;
         result <= '0;
         valid  <= 1'b0;
      end else begin
         if (cnt_done || state == IDLE || state == DECIDE) cnt <= '0;
         else                                               cnt <= cnt + 1'b1;

         // A result write below overrides a same-cycle transfer.
         if (valid && ready_i) valid <= 1'b0;

         case (state)
            SAMPLE: begin
               if (cnt_done) begin
                  sar <= {1'b1, {(WIDTH-1){1'b0}}};
                  idx <= IDX_W'(WIDTH - 1);
               end
            end
            DECIDE: begin
               if (idx == '0) begin
                  result <= decided;
                  valid  <= 1'b1;
                  sar    <= '0;
               end else begin
                  sar <= next_trial;
                  idx <= idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sample_o = (state == SAMPLE);
   assign busy_o   = (state != IDLE);
   assign dac_o    = sar;
   assign result_o = result;
   assign valid_o  = valid;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// +--------------------------------------------------------------+
// | tb_sar_adc_ctrl : directed bench with an ideal comparator     |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module tb_sar_adc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic       comp_i;
   logic       sample_o;
   logic [7:0] dac_o;
   logic       busy_o;
   logic [7:0] result_o;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] vin;
   logic [7:0] seq_a5 [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign comp_i = (vin >= dac_o);

   sar_adc_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .comp_i   (comp_i),
      .sample_o (sample_o),
      .dac_o    (dac_o),
      .busy_o   (busy_o),
      .result_o (result_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One start pulse, then walk cycles 1..29 of the conversion.
   task automatic conv(input logic [7:0] v, input bit chk_seq);
      vin     = v;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 28; c++) begin
         if (c == 1)  check("busy_c1", busy_o, 1);
         if (c == 1)  check("sample_c1", sample_o, 1);
         if (c == 4)  check("sample_c4", sample_o, 1);
         if (c == 5)  check("sample_c5", sample_o, 0);
         if (c == 28) check("busy_c28", busy_o, 1);
         if (c == 28) check("valid_c28", valid_o, 0);
         if (chk_seq && c >= 5 && ((c - 5) % 3) == 0)
            check($sformatf("dac_c%0d", c), dac_o, seq_a5[(c - 5) / 3]);
         tick();
      end
      check("valid_c29", valid_o, 1);
      check("result_c29", result_o, v);
      check("busy_c29", busy_o, 0);
      check("dac_c29", dac_o, 0);
      tick();
      check("valid_c30", valid_o, 0);
   endtask

   initial begin
      int n;
      int pulses;
      int busy_cnt;
      seq_a5  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      rst     = 1'b1;
      start_i = 1'b0;
      ready_i = 1'b1;
      vin     = 8'h00;
      repeat (2) tick();
      check("rst_sample", sample_o, 0);
      check("rst_dac", dac_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_result", result_o, 0);
      check("rst_valid", valid_o, 0);
      rst = 1'b0;
      tick();

      conv(8'hA5, 1'b1);
      conv(8'h00, 1'b0);
      conv(8'hFF, 1'b0);

      // Blocked output register holds the sample and stalls the next start.
      vin     = 8'h33;
      ready_i = 1'b0;
      start_i = 1'b1;
      tick();
      n = 1;
      while (!valid_o && n < 100) begin
         tick();
         n++;
      end
      check("hold_latency", n, 29);
      check("hold_result", result_o, 8'h33);
      for (int i = 0; i < 40; i++) begin
         check("hold_valid", valid_o, 1);
         check("hold_data", result_o, 8'h33);
         check("hold_nosample", sample_o, 0);
         tick();
      end
      ready_i = 1'b1;
      tick();
      check("release_sample", sample_o, 1);
      check("release_valid", valid_o, 0);
      start_i = 1'b0;
      repeat (28) tick();
      check("release_valid29", valid_o, 1);
      check("release_result", result_o, 8'h33);
      tick();

      // Back-to-back conversions with start held.
      vin     = 8'h5A;
      start_i = 1'b1;
      tick();
      pulses = 0;
      for (int c = 1; c <= 87; c++) begin
         if (valid_o) pulses++;
         if (c == 29 || c == 58 || c == 87) begin
            check($sformatf("b2b_valid_c%0d", c), valid_o, 1);
            check($sformatf("b2b_result_c%0d", c), result_o, 8'h5A);
         end
         if (c == 87) start_i = 1'b0;
         tick();
      end
      check("b2b_pulses", pulses, 3);
      check("b2b_idle", busy_o, 0);
      tick();

      // Start pulse mid-conversion is ignored.
      vin     = 8'h6E;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (9) tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (18) tick();
      check("ign_valid", valid_o, 1);
      check("ign_result", result_o, 8'h6E);
      pulses   = 0;
      busy_cnt = 0;
      repeat (40) begin
         tick();
         if (valid_o) pulses++;
         if (busy_o)  busy_cnt++;
      end
      check("ign_extra_valid", pulses, 0);
      check("ign_extra_busy", busy_cnt, 0);

      // Reset in the middle of a conversion.
      vin     = 8'h77;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (14) tick();
      check("mid_busy_c15", busy_o, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_sample", sample_o, 0);
      check("mid_rst_dac", dac_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_result", result_o, 0);
      check("mid_rst_valid", valid_o, 0);
      rst = 1'b0;
      tick();
      conv(8'h3C, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
